// File: rtl/sram_access_controller.sv
// sram_access_controller
//   MEM-stage memory access unit. Each 32-bit load/store from the pipeline is
//   carried out as two 16-bit accesses, low half then high half, on an
//   external SRAM bus. Each half access lasts ACCESS_CYCLES cycles.
//   'ready' is low while an access is in flight so the freeze logic can
//   stall the pipeline.
//
// Parameters
//   BASE_ADDR      byte address mapped to SRAM word 0
//   SRAM_AW        SRAM halfword address width
//   ACCESS_CYCLES  cycles per 16-bit half access (1..15)
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   MEM_R_EN     load request
//   MEM_W_EN     store request (wins over MEM_R_EN)
//   ALU_Res      byte address of the request
//   Val_Rm       store data
//   read_data    load result; holds until the next load's low-half sample
//   ready        1 when idle with no request, or for the single DONE cycle
//   SRAM_ADDR    halfword address (0 when idle)
//   SRAM_WE_N    write strobe, active-low
//   SRAM_DQ_OUT  write data driven to the SRAM
//   SRAM_DQ_OE   1 = controller drives the data bus
//   SRAM_DQ_IN   read data from the SRAM
module sram_access_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int SRAM_AW       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic [15:0]        SRAM_DQ_OUT,
  output logic               SRAM_DQ_OE,
  input  logic [15:0]        SRAM_DQ_IN
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic               req;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] idx;
  logic               unused_offset_bits;

  logic [SRAM_AW-2:0] idx_p0;
  logic [31:0]        wdata_p0;
  logic               wr_p0;

  assign req = MEM_R_EN | MEM_W_EN;

  // Word index; bits above the SRAM range are dropped so out-of-range
  // addresses (including those below BASE_ADDR) wrap around.
  assign offset             = ALU_Res - 32'(BASE_ADDR);
  assign idx                = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // ready is combinational so the stall is raised in the same cycle the
  // request first appears.
  assign ready = (state == DONE) || ((state == IDLE) && !req);

  // ---- request latch stage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      idx_p0   <= idx;
      wdata_p0 <= Val_Rm;
      wr_p0    <= MEM_W_EN;
    end
  end

  // ---- access sequencer: state, counter and registered bus outputs ----
  // The bus outputs are loaded on the edge that enters each state, so the
  // low-half values come straight from the request inputs (the latch above
  // is being written on that same edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      read_data   <= '0;
      SRAM_ADDR   <= '0;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_DQ_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LOW;
            cnt         <= '0;
            SRAM_ADDR   <= {idx, 1'b0};
            SRAM_WE_N   <= ~MEM_W_EN;
            SRAM_DQ_OE  <= MEM_W_EN;
            SRAM_DQ_OUT <= Val_Rm[15:0];
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            if (!wr_p0) read_data[15:0] <= SRAM_DQ_IN;
            state       <= HIGH;
            cnt         <= '0;
            SRAM_ADDR   <= {idx_p0, 1'b1};
            SRAM_DQ_OUT <= wdata_p0[31:16];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            if (!wr_p0) read_data[31:16] <= SRAM_DQ_IN;
            state      <= DONE;
            cnt        <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Testbench for sram_access_controller: table of load/store vectors run
// back-to-back, plus hand-written back-to-back and reset-abort sequences.
// A behavioural SRAM sits on the bus; expected load words and latencies are
// queued at issue and compared when ready pulses.
module tb_sram_access_controller;

  localparam int AC  = 2;
  localparam int AW  = 18;
  localparam int LAT = 2 * AC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   ALU_Res, Val_Rm;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE_N;
  logic [15:0]   SRAM_DQ_OUT;
  logic          SRAM_DQ_OE;
  logic [15:0]   SRAM_DQ_IN;

  sram_access_controller #(
    .BASE_ADDR(1024), .SRAM_AW(AW), .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_OUT(SRAM_DQ_OUT),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_IN(SRAM_DQ_IN)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: asynchronous read, write on rising edge while strobed.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign SRAM_DQ_IN = sram_mem[SRAM_ADDR];
  always @(posedge clk)
    if (!rst && !SRAM_WE_N && SRAM_DQ_OE) sram_mem[SRAM_ADDR] <= SRAM_DQ_OUT;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic          r;
    logic          w;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [AW-1:0] lo;
    logic [31:0]   exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int unsigned t;
  } sb_t;

  sb_t         sb[$];
  int unsigned done_t[$];
  logic        prev_ready = 1'b1;

  // Completion monitor: a rising ready marks a DONE cycle.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (ready && !prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(ready), 32'h0);
        end else begin
          e = sb.pop_front();
          check("read_data", read_data, e.rd);
          check("latency", 32'(cyc - e.t), 32'(LAT));
          done_t.push_back(cyc);
        end
      end
    end
    prev_ready = ready;
  end

  // Called just after a rising edge with the DUT idle; returns just after
  // the edge that leaves DONE, so calls chain back-to-back.
  task automatic access(input vec_t v);
    int hi;
    MEM_R_EN = v.r;
    MEM_W_EN = v.w;
    ALU_Res  = v.addr;
    Val_Rm   = v.data;
    sb.push_back('{rd: v.exp_rd, t: cyc});
    @(negedge clk);
    check("ready_c0", 32'(ready), 32'h0);
    for (int k = 1; k <= 2 * AC; k++) begin
      @(negedge clk);
      hi = (k > AC) ? 1 : 0;
      check("ready_busy", 32'(ready), 32'h0);
      check("addr", 32'(SRAM_ADDR), 32'(v.lo) + 32'(hi));
      check("we_n", 32'(SRAM_WE_N), 32'(!v.w));
      check("oe", 32'(SRAM_DQ_OE), 32'(v.w));
      if (v.w) check("dq_out", 32'(SRAM_DQ_OUT), hi ? 32'(v.data[31:16]) : 32'(v.data[15:0]));
    end
    @(negedge clk);
    check("done_we_n", 32'(SRAM_WE_N), 32'h1);
    check("done_oe", 32'(SRAM_DQ_OE), 32'h0);
    check("done_addr", 32'(SRAM_ADDR), 32'h0);
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   n0;

    tbl[0] = '{r: 1'b0, w: 1'b1, addr: 32'd1024,    data: 32'h12345678, lo: 18'd0,       exp_rd: 32'h00000000};
    tbl[1] = '{r: 1'b1, w: 1'b0, addr: 32'd1044,    data: 32'h0,        lo: 18'd10,      exp_rd: 32'hCAFEBEEF};
    tbl[2] = '{r: 1'b1, w: 1'b0, addr: 32'd1024,    data: 32'h0,        lo: 18'd0,       exp_rd: 32'h12345678};
    tbl[3] = '{r: 1'b1, w: 1'b1, addr: 32'd1028,    data: 32'hA5A55A5A, lo: 18'd2,       exp_rd: 32'h12345678};
    tbl[4] = '{r: 1'b1, w: 1'b0, addr: 32'd1028,    data: 32'h0,        lo: 18'd2,       exp_rd: 32'hA5A55A5A};
    tbl[5] = '{r: 1'b0, w: 1'b1, addr: 32'h00080404, data: 32'hDEADBEEF, lo: 18'd2,      exp_rd: 32'hA5A55A5A};
    tbl[6] = '{r: 1'b1, w: 1'b0, addr: 32'd1028,    data: 32'h0,        lo: 18'd2,       exp_rd: 32'hDEADBEEF};
    tbl[7] = '{r: 1'b1, w: 1'b0, addr: 32'd1020,    data: 32'h0,        lo: 18'h3FFFE,   exp_rd: 32'h22221111};

    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    sram_mem[10]      = 16'hBEEF;
    sram_mem[11]      = 16'hCAFE;
    sram_mem[18'h3FFFE] = 16'h1111;
    sram_mem[18'h3FFFF] = 16'h2222;

    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res = 32'h0;
    Val_Rm = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_we_n", 32'(SRAM_WE_N), 32'h1);
    check("rst_oe", 32'(SRAM_DQ_OE), 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_addr", 32'(SRAM_ADDR), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) access(tbl[i]);

    // Store then load to the same word, back-to-back.
    n0 = done_t.size();
    v = '{r: 1'b0, w: 1'b1, addr: 32'd2048, data: 32'h0F1E2D3C, lo: 18'd512, exp_rd: 32'h22221111};
    access(v);
    v = '{r: 1'b1, w: 1'b0, addr: 32'd2048, data: 32'h0, lo: 18'd512, exp_rd: 32'h0F1E2D3C};
    access(v);
    check("b2b_pulses", 32'(done_t.size() - n0), 32'd2);
    if (done_t.size() - n0 == 2)
      check("b2b_spacing", 32'(done_t[n0+1] - done_t[n0]), 32'd6);

    // Store aborted by reset while the high half is on the bus.
    MEM_W_EN = 1'b1;
    ALU_Res  = 32'd1036;
    Val_Rm   = 32'h0BADF00D;
    repeat (AC + 2) @(negedge clk);
    check("abort_in_high_addr", 32'(SRAM_ADDR), 32'd7);
    check("abort_in_high_we_n", 32'(SRAM_WE_N), 32'h0);
    #2;
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    #1;
    check("abort_we_n", 32'(SRAM_WE_N), 32'h1);
    check("abort_oe", 32'(SRAM_DQ_OE), 32'h0);
    check("abort_addr", 32'(SRAM_ADDR), 32'h0);
    check("abort_dq_out", 32'(SRAM_DQ_OUT), 32'h0);
    check("abort_read_data", read_data, 32'h0);
    check("abort_ready", 32'(ready), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Only the low half of the aborted store reached the SRAM.
    v = '{r: 1'b1, w: 1'b0, addr: 32'd1036, data: 32'h0, lo: 18'd6, exp_rd: 32'h0000F00D};
    access(v);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
